// File: rtl/data_sram_responder.sv
// Responder end of the core's data SRAM port: word memory with byte-lane writes,
// one-cycle registered read data, a post-reset clearing sweep and a sticky window-error flag.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_busy,
  output logic        addr_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] init_ptr;
  logic [ADDR_WIDTH-1:0] index;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           merged;
  logic                  in_window;
  logic                  access;
  logic                  unused_addr;

  assign in_window   = (data_sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign index       = data_sram_addr[ADDR_WIDTH+1:2];
  assign access      = (state == READY) && data_sram_en;
  assign unused_addr = ^data_sram_addr[1:0];

  // Post-write word: written lanes take wdata, the rest keep the stored bytes.
  always_comb begin
    merged = mem[index];
    for (int i = 0; i < 4; i++) begin
      if (data_sram_wen[i]) merged[8*i +: 8] = data_sram_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    init_busy  = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (init_ptr == ADDR_WIDTH'(DEPTH - 1)) state_next = READY;
      end
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_ptr        <= '0;
      data_sram_rdata <= '0;
      addr_err        <= 1'b0;
    end else begin
      if (state == INIT) init_ptr <= init_ptr + 1'b1;
      if (access) begin
        if (in_window) begin
          data_sram_rdata <= merged;
        end else begin
          data_sram_rdata <= '0;
          addr_err        <= 1'b1;
        end
      end
    end
  end

  // Storage has no reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (state == INIT)              mem[init_ptr] <= '0;
    else if (access && in_window)   mem[index]    <= merged;
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: a spec-level model checked every cycle,
// plus hand-computed literal checks at the key points of the test plan.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  int n_vec  = 0;
  int n_miss = 0;

  data_sram_responder #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .init_busy       (busy),
    .addr_err        (err)
  );

  always #5 clk = ~clk;

  // Model: sweep is "16 cycles since reset", memory is a plain word array.
  logic [31:0] m_mem [16];
  logic [31:0] m_rdata;
  logic        m_err;
  int          m_cycles;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cycles = 0;
      m_rdata  = 32'h0;
      m_err    = 1'b0;
    end else if (m_cycles < 16) begin
      m_cycles = m_cycles + 1;
      if (m_cycles == 16) for (int k = 0; k < 16; k++) m_mem[k] = 32'h0;
    end else if (en) begin
      if (addr[31:6] == 26'h0) begin
        for (int i = 0; i < 4; i++)
          if (wen[i]) m_mem[addr[5:2]][8*i +: 8] = wdata[8*i +: 8];
        m_rdata = m_mem[addr[5:2]];
      end else begin
        m_rdata = 32'h0;
        m_err   = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("model_rdata", rdata, m_rdata);
      check("model_busy", {31'h0, busy}, {31'h0, (m_cycles < 16)});
      check("model_err", {31'h0, err}, {31'h0, m_err});
    end
  end

  task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    #1;
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(name, cnt, 16);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    #12;
    check("reset_busy", {31'h0, busy}, 32'h1);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    @(negedge clk); rst = 1'b0;
    count_busy("sweep_len");

    for (int a = 0; a < 16; a++) req(1'b1, 4'h0, 32'(a * 4), 32'h0);
    idle();
    check("lw_after_sweep", rdata, 32'h0);

    req(1'b1, 4'hF, 32'h08, 32'hDEAD_BEEF);
    idle();
    check("sw_write_first", rdata, 32'hDEAD_BEEF);
    req(1'b1, 4'h0, 32'h08, 32'h0);
    idle();
    check("lw_after_sw", rdata, 32'hDEAD_BEEF);

    req(1'b1, 4'b0100, 32'h0A, 32'h0055_0000);
    idle();
    check("byte_lane", rdata, 32'hDE55_BEEF);

    req(1'b1, 4'hF, 32'h40, 32'h1234_5678);
    idle();
    check("oow_rdata", rdata, 32'h0);
    check("oow_err", {31'h0, err}, 32'h1);
    req(1'b1, 4'h0, 32'h00, 32'h0);
    idle();
    check("lw0_after_oow", rdata, 32'h0);
    check("err_sticky", {31'h0, err}, 32'h1);

    // Back-to-back mixed lane patterns, read-after-write and a hold cycle.
    req(1'b1, 4'b0011, 32'h3C, 32'hAAAA_5555);
    req(1'b1, 4'b1000, 32'h3D, 32'h7700_0000);
    req(1'b1, 4'h0, 32'h3C, 32'h0);
    idle();
    check("mixed_lanes", rdata, 32'h7700_5555);
    idle();
    check("rdata_hold", rdata, 32'h7700_5555);
    req(1'b1, 4'b1001, 32'h08, 32'h1100_0022);
    req(1'b1, 4'h0, 32'hFFFF_FFC0, 32'h0);
    req(1'b1, 4'h0, 32'h08, 32'h0);
    idle();
    check("lanes_1001", rdata, 32'h1155_BE22);

    // Asynchronous reset mid-operation.
    @(posedge clk); #2; rst = 1'b1; #1;
    check("midop_err_clr", {31'h0, err}, 32'h0);
    check("midop_busy", {31'h0, busy}, 32'h1);
    check("midop_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    repeat (3) @(posedge clk);
    req(1'b1, 4'hF, 32'h04, 32'hFFFF_FFFF);
    idle();
    check("init_ignore_rd", rdata, 32'h0);
    repeat (4) @(posedge clk);
    check("pre_midsweep_busy", {31'h0, busy}, 32'h1);
    #2; rst = 1'b1; #1;
    check("midsweep_busy", {31'h0, busy}, 32'h1);
    check("midsweep_err", {31'h0, err}, 32'h0);
    @(negedge clk); rst = 1'b0;
    count_busy("restart_sweep_len");

    req(1'b1, 4'h0, 32'h04, 32'h0);
    idle();
    check("init_write_ignored", rdata, 32'h0);
    req(1'b1, 4'h0, 32'h08, 32'h0);
    idle();
    check("sweep_cleared", rdata, 32'h0);
    check("err_after_reset", {31'h0, err}, 32'h0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
